r_result_serializer: RTL and testbench

//  Output-side counterpart of the 32-bit operand word loader. Captures the 512-bit
//  RSA result (m) from the r512 core in one cycle, then streams it out as 16 x 32-bit

---
 rtl/r_pkg.sv | 14 +
 rtl/r_result_serializer.sv | 71 +++++++
 tb/tb_r_result_serializer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/r_pkg.sv
// Constants and state encoding shared by the operand loader, r512 and the result serializer.
package r_pkg;

  localparam int RSA_W     = 512;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = RSA_W / WORD_W;
  localparam int IDX_W     = $clog2(NUM_WORDS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/r_result_serializer.sv
// Captures a 512-bit r512 result in one cycle and streams it out as 32-bit words,
// least-significant word first, over a valid/ready handshake.
module r_result_serializer #(
  parameter int DATA_W    = r_pkg::RSA_W,
  parameter int WORD_W    = r_pkg::WORD_W,
  parameter int NUM_WORDS = DATA_W / WORD_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [DATA_W-1:0]       din,
  output logic                    in_ready,
  output logic [WORD_W-1:0]       m,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic [r_pkg::IDX_W-1:0] word_idx,
  output logic                    done
);

  localparam logic [r_pkg::IDX_W-1:0] LAST_IDX = r_pkg::IDX_W'(NUM_WORDS - 1);

  r_pkg::state_e             state_q;
  logic [DATA_W-1:0]         shreg_q;
  logic [r_pkg::IDX_W-1:0]   idx_q;
  logic                      done_q;

  // NOTE: the wide shift register is reset as well, so m reads 0 whenever idle
  // and a partial result never leaks out after a mid-result reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= r_pkg::IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        r_pkg::IDLE: begin
          if (load) begin
            shreg_q <= din;
            idx_q   <= '0;
            state_q <= r_pkg::SEND;
          end
        end
        r_pkg::SEND: begin
          if (m_ready) begin
            shreg_q <= shreg_q >> WORD_W;
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              done_q  <= 1'b1;
              state_q <= r_pkg::IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= r_pkg::IDLE;
      endcase
    end
  end

  // All outputs come straight from flops; the last-word flag is a compare on the index flop.
  assign in_ready = (state_q == r_pkg::IDLE);
  assign m_valid  = (state_q == r_pkg::SEND);
  assign m        = shreg_q[WORD_W-1:0];
  assign m_last   = (state_q == r_pkg::SEND) && (idx_q == LAST_IDX);
  assign word_idx = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_r_result_serializer.sv
// Directed bench for r_result_serializer: full-rate, throttled, ignored loads,
// asynchronous mid-result reset and continuous load.
module tb_r_result_serializer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [511:0] din = '0;
  logic         in_ready;
  logic [31:0]  m;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         m_last;
  logic [3:0]   word_idx;
  logic         done;

  int checks = 0;
  int failures = 0;

  logic [511:0] pattern;
  logic [31:0]  exp_words [16];

  r_result_serializer dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .din      (din),
    .in_ready (in_ready),
    .m        (m),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .word_idx (word_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m"}, m, 32'd0);
    check({tag, "_word_idx"}, 32'(word_idx), 32'd0);
    check({tag, "_m_last"}, 32'(m_last), 32'd0);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
  endtask

  // Called in the first SEND cycle. ready_mode 0: m_ready always 1; 1: pattern 1,0,0.
  // load_mode 0: no load; 1: pulse at beat 5 and on the last beat; 2: held high.
  // Returns in the done cycle with load left at (load_mode == 2).
  task automatic stream(input string tag, input int ready_mode, input int load_mode);
    int k = 0;
    int cyc = 0;
    while (k < 16 && cyc < 200) begin
      m_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      case (load_mode)
        1:       load = (k == 5) || (k == 15 && m_ready);
        2:       load = 1'b1;
        default: load = 1'b0;
      endcase
      #1;
      check({tag, "_m"}, m, exp_words[k]);
      check({tag, "_idx"}, 32'(word_idx), 32'(k));
      check({tag, "_last"}, 32'(m_last), 32'(k == 15));
      check({tag, "_valid"}, 32'(m_valid), 32'd1);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      if (m_ready) k++;
      tick();
      cyc++;
    end
    check({tag, "_beats"}, 32'(k), 32'd16);
    check({tag, "_cycles"}, 32'(cyc), (ready_mode == 0) ? 32'd16 : 32'd46);
    m_ready = 1'b0;
    load    = (load_mode == 2);
    check_idle({tag, "_end"}, 1'b1);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) pattern[k*32 +: 32] = 32'(k);

    // Reset state
    #2 rst = 1'b1;
    #2 check_idle("reset", 1'b0);
    tick();
    tick();
    rst = 1'b0;
    check_idle("post_reset", 1'b0);

    // 1: full-rate stream of word k = k
    for (int k = 0; k < 16; k++) exp_words[k] = 32'(k);
    din  = pattern;
    load = 1'b1;
    #1 check("t1_valid_same_cycle", 32'(m_valid), 32'd0);
    tick();
    load = 1'b0;
    stream("t1", 0, 0);
    tick();
    check_idle("t1_after", 1'b0);

    // 2: throttled stream
    load = 1'b1;
    tick();
    load = 1'b0;
    stream("t2", 1, 0);
    tick();
    check_idle("t2_after", 1'b0);

    // 3: loads during SEND and on the last beat are ignored
    load = 1'b1;
    tick();
    din = '1;
    stream("t3", 0, 1);
    tick();
    check_idle("t3_no_restart", 1'b0);
    din  = pattern;
    load = 1'b1;
    tick();
    load = 1'b0;
    check("t3_restart_valid", 32'(m_valid), 32'd1);
    check("t3_restart_m", m, 32'd0);

    // 4: asynchronous reset mid-result at beat 7
    m_ready = 1'b1;
    repeat (7) tick();
    check("t4_idx_before", 32'(word_idx), 32'd7);
    check("t4_m_before", m, 32'd7);
    #2 rst = 1'b1;
    #1 check_idle("t4_async", 1'b0);
    m_ready = 1'b0;
    tick();
    rst  = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    stream("t4_fresh", 0, 0);
    tick();

    // 5: load held high, all-ones then all-zeros, one IDLE cycle between
    for (int k = 0; k < 16; k++) exp_words[k] = 32'hFFFF_FFFF;
    din  = '1;
    load = 1'b1;
    tick();
    din = '0;
    stream("t5_ones", 0, 2);
    tick();
    for (int k = 0; k < 16; k++) exp_words[k] = 32'h0;
    stream("t5_zeros", 0, 2);
    load = 1'b0;
    tick();
    check_idle("t5_after", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
